// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: pipeline request/response and shared memory bus signals of mem_bus_arbiter
interface mem_bus_arbiter_if;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        if_valid;
  logic        mem_valid;
  logic [31:0] if_rdata;
  logic [31:0] mem_rdata;
  logic        if_stall_req;
  logic        mem_stall_req;
  logic        bus_err;
  modport master (
    input  flush, if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  bus_ready, bus_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output if_valid, mem_valid, if_rdata, mem_rdata, if_stall_req, mem_stall_req, bus_err
  );
  modport slave (
    output flush, if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output bus_ready, bus_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  if_valid, mem_valid, if_rdata, mem_rdata, if_stall_req, mem_stall_req, bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: IF/MEM arbiter for one shared memory bus; ARB_TIMEOUT_EN adds a bus-ready watchdog
module mem_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  mem_bus_arbiter_if.master arb
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic owner;
  logic last_grant;
  logic cancel;
  logic if_pend;
  logic grant;
  logic grant_mem;
  logic cancel_n;
  logic fin;
  logic tmo;
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT must be within 2..255");
  end
  // owner / last_grant: 0 = IF, 1 = MEM
  assign if_pend   = arb.if_req & ~arb.flush;
  assign grant     = if_pend | arb.mem_req;
  assign grant_mem = arb.mem_req & (~if_pend | ~last_grant);
  assign cancel_n  = cancel | (arb.flush & ~owner & (state != IDLE));
  assign fin       = (state == BUSY) & (arb.bus_ready | tmo);
  assign arb.if_valid      = (state == DONE) & ~owner & ~cancel;
  assign arb.mem_valid     = (state == DONE) & owner;
  assign arb.if_stall_req  = arb.if_req & ~arb.if_valid;
  assign arb.mem_stall_req = arb.mem_req & ~arb.mem_valid;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  logic err;
  assign tmo = (state == BUSY) & ~arb.bus_ready & (cnt == 8'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    cnt <= (reset | (state != BUSY) | arb.bus_ready) ? 8'd0 : cnt + 8'd1;
    err <= ~reset & tmo;
  end
  assign arb.bus_err = err;
`else
  assign tmo = 1'b0;
  assign arb.bus_err = 1'b0;
`endif
  // a timed-out transaction completes with zero read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b0;
      cancel        <= 1'b0;
      arb.bus_req   <= 1'b0;
      arb.bus_we    <= 1'b0;
      arb.bus_addr  <= '0;
      arb.bus_wdata <= '0;
      arb.bus_wstrb <= '0;
      arb.if_rdata  <= '0;
      arb.mem_rdata <= '0;
    end else if (state == IDLE) begin
      cancel <= 1'b0;
      if (grant) begin
        state         <= BUSY;
        owner         <= grant_mem;
        last_grant    <= grant_mem;
        arb.bus_req   <= 1'b1;
        arb.bus_we    <= grant_mem & arb.mem_we;
        arb.bus_addr  <= grant_mem ? arb.mem_addr : arb.if_addr;
        arb.bus_wdata <= grant_mem ? arb.mem_wdata : 32'd0;
        arb.bus_wstrb <= grant_mem ? arb.mem_wstrb : 4'd0;
      end
    end else if (state == BUSY) begin
      cancel <= cancel_n;
      if (fin) begin
        state       <= DONE;
        arb.bus_req <= 1'b0;
        if (owner & ~arb.bus_we)
          arb.mem_rdata <= arb.bus_ready ? arb.bus_rdata : 32'd0;
        if (~owner & ~cancel_n)
          arb.if_rdata <= arb.bus_ready ? arb.bus_rdata : 32'd0;
      end
    end else begin
      state  <= IDLE;
      cancel <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: per-cycle vector table plus hand-written reset and watchdog sequences
module tb_mem_bus_arbiter;
  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] C = 32'hCAFE0001;
  localparam logic [31:0] E = 32'h11112222;
  localparam logic [31:0] S = 32'h12345678;
  localparam logic [31:0] G = 32'h600D0001;
  localparam int N = 36;
  typedef struct {
    logic [31:0] rst, fl, ir, ia, mr, mw, ma, md, ms, rdy, rd;
  } in_t;
  typedef struct {
    logic [31:0] bq, bw, ba, bd, bs, iv, mv, ird, mrd, is, mst;
  } out_t;
  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int row = 0;
  vec_t tab[N];
  mem_bus_arbiter_if b ();
  mem_bus_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .arb(b));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s row %0d: got %h want %h", n, row, a, e);
    end
  endtask
  task automatic drive(input in_t v);
    reset       = v.rst[0];
    b.flush     = v.fl[0];
    b.if_req    = v.ir[0];
    b.if_addr   = v.ia;
    b.mem_req   = v.mr[0];
    b.mem_we    = v.mw[0];
    b.mem_addr  = v.ma;
    b.mem_wdata = v.md;
    b.mem_wstrb = v.ms[3:0];
    b.bus_ready = v.rdy[0];
    b.bus_rdata = v.rd;
  endtask
  initial begin
    logic got;
    int n;
    tab[0]  = '{'{0,0,0,0,0,0,0,0,0,0,0},           '{0,0,0,0,0,0,0,0,0,0,0}};
    tab[1]  = '{'{0,0,1,'h100,0,0,0,0,0,0,0},       '{0,0,0,0,0,0,0,0,0,1,0}};
    tab[2]  = '{'{0,0,1,'h100,0,0,0,0,0,1,D},       '{1,0,'h100,0,0,0,0,0,0,1,0}};
    tab[3]  = '{'{0,0,1,'h100,0,0,0,0,0,0,0},       '{0,0,'h100,0,0,1,0,D,0,0,0}};
    tab[4]  = '{'{0,0,0,0,0,0,0,0,0,0,0},           '{0,0,'h100,0,0,0,0,D,0,0,0}};
    tab[5]  = '{'{1,0,0,0,0,0,0,0,0,0,0},           '{0,0,'h100,0,0,0,0,D,0,0,0}};
    tab[6]  = '{'{0,0,0,0,0,0,0,0,0,0,0},           '{0,0,0,0,0,0,0,0,0,0,0}};
    tab[7]  = '{'{0,0,1,'h200,1,0,'h2000,0,0,0,0},  '{0,0,0,0,0,0,0,0,0,1,1}};
    tab[8]  = '{'{0,0,1,'h200,1,0,'h2000,0,0,1,C},  '{1,0,'h2000,0,0,0,0,0,0,1,1}};
    tab[9]  = '{'{0,0,1,'h200,1,0,'h2000,0,0,0,0},  '{0,0,'h2000,0,0,0,1,0,C,1,0}};
    tab[10] = '{'{0,0,1,'h200,0,0,0,0,0,0,0},       '{0,0,'h2000,0,0,0,0,0,C,1,0}};
    tab[11] = '{'{0,0,1,'h200,0,0,0,0,0,1,E},       '{1,0,'h200,0,0,0,0,0,C,1,0}};
    tab[12] = '{'{0,0,1,'h200,0,0,0,0,0,0,0},       '{0,0,'h200,0,0,1,0,E,C,0,0}};
    tab[13] = '{'{0,0,1,'h300,1,0,'h2004,0,0,0,0},  '{0,0,'h200,0,0,0,0,E,C,1,1}};
    tab[14] = '{'{0,0,1,'h300,1,0,'h2004,0,0,1,'h55}, '{1,0,'h2004,0,0,0,0,E,C,1,1}};
    tab[15] = '{'{0,0,1,'h300,1,0,'h2004,0,0,0,0},  '{0,0,'h2004,0,0,0,1,E,'h55,1,0}};
    tab[16] = '{'{0,0,0,0,0,0,0,0,0,0,0},           '{0,0,'h2004,0,0,0,0,E,'h55,0,0}};
    tab[17] = '{'{0,0,0,0,1,1,'h40,S,3,0,0},        '{0,0,'h2004,0,0,0,0,E,'h55,0,1}};
    tab[18] = '{'{0,0,0,0,1,1,'h40,S,3,1,'hFFFFFFFF}, '{1,1,'h40,S,3,0,0,E,'h55,0,1}};
    tab[19] = '{'{0,0,0,0,1,1,'h40,S,3,0,0},        '{0,1,'h40,S,3,0,1,E,'h55,0,0}};
    tab[20] = '{'{0,0,0,0,0,0,0,0,0,0,0},           '{0,1,'h40,S,3,0,0,E,'h55,0,0}};
    tab[21] = '{'{0,0,1,'h400,0,0,0,0,0,0,0},       '{0,1,'h40,S,3,0,0,E,'h55,1,0}};
    tab[22] = '{'{0,0,1,'h400,0,0,0,0,0,0,0},       '{1,0,'h400,0,0,0,0,E,'h55,1,0}};
    tab[23] = '{'{0,1,1,'h400,0,0,0,0,0,0,0},       '{1,0,'h400,0,0,0,0,E,'h55,1,0}};
    tab[24] = '{'{0,0,0,0,0,0,0,0,0,0,0},           '{1,0,'h400,0,0,0,0,E,'h55,0,0}};
    tab[25] = '{'{0,0,0,0,0,0,0,0,0,1,'hBAD0BAD0},  '{1,0,'h400,0,0,0,0,E,'h55,0,0}};
    tab[26] = '{'{0,0,0,0,0,0,0,0,0,0,0},           '{0,0,'h400,0,0,0,0,E,'h55,0,0}};
    tab[27] = '{'{0,0,1,'h500,0,0,0,0,0,0,0},       '{0,0,'h400,0,0,0,0,E,'h55,1,0}};
    tab[28] = '{'{0,0,1,'h500,0,0,0,0,0,1,G},       '{1,0,'h500,0,0,0,0,E,'h55,1,0}};
    tab[29] = '{'{0,0,1,'h500,0,0,0,0,0,0,0},       '{0,0,'h500,0,0,1,0,G,'h55,0,0}};
    tab[30] = '{'{0,0,0,0,0,0,0,0,0,0,0},           '{0,0,'h500,0,0,0,0,G,'h55,0,0}};
    tab[31] = '{'{0,1,1,'h700,0,0,0,0,0,0,0},       '{0,0,'h500,0,0,0,0,G,'h55,1,0}};
    tab[32] = '{'{0,0,1,'h700,0,0,0,0,0,0,0},       '{0,0,'h500,0,0,0,0,G,'h55,1,0}};
    tab[33] = '{'{0,0,1,'h700,0,0,0,0,0,1,'h77},    '{1,0,'h700,0,0,0,0,G,'h55,1,0}};
    tab[34] = '{'{0,0,1,'h700,0,0,0,0,0,0,0},       '{0,0,'h700,0,0,1,0,'h77,'h55,0,0}};
    tab[35] = '{'{0,0,0,0,0,0,0,0,0,0,0},           '{0,0,'h700,0,0,0,0,'h77,'h55,0,0}};
    drive(tab[0].i);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < N; i++) begin
      row = i;
      @(negedge clk);
      drive(tab[i].i);
      #1;
      chk("bus_req",       32'(b.bus_req),       tab[i].o.bq);
      chk("bus_we",        32'(b.bus_we),        tab[i].o.bw);
      chk("bus_addr",      b.bus_addr,           tab[i].o.ba);
      chk("bus_wdata",     b.bus_wdata,          tab[i].o.bd);
      chk("bus_wstrb",     32'(b.bus_wstrb),     tab[i].o.bs);
      chk("if_valid",      32'(b.if_valid),      tab[i].o.iv);
      chk("mem_valid",     32'(b.mem_valid),     tab[i].o.mv);
      chk("if_rdata",      b.if_rdata,           tab[i].o.ird);
      chk("mem_rdata",     b.mem_rdata,          tab[i].o.mrd);
      chk("if_stall_req",  32'(b.if_stall_req),  tab[i].o.is);
      chk("mem_stall_req", 32'(b.mem_stall_req), tab[i].o.mst);
      chk("bus_err",       32'(b.bus_err),       32'd0);
    end
    // reset during a MEM load abandons it without a valid pulse
    row = N;
    b.mem_req  = 1'b1;
    b.mem_we   = 1'b0;
    b.mem_addr = 32'h3000;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b.bus_req) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_busy_grant", 32'(got), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    b.mem_req = 1'b0;
    #1;
    chk("rst_busy_bus_req",   32'(b.bus_req),   32'd0);
    chk("rst_busy_mem_valid", 32'(b.mem_valid), 32'd0);
    chk("rst_busy_bus_addr",  b.bus_addr,       32'd0);
    chk("rst_busy_mem_rdata", b.mem_rdata,      32'd0);
    @(negedge clk);
    #1;
    chk("rst_after_mem_valid", 32'(b.mem_valid), 32'd0);
    chk("rst_after_bus_req",   32'(b.bus_req),   32'd0);
`ifdef ARB_TIMEOUT_EN
    row = N + 1;
    b.mem_req  = 1'b1;
    b.mem_addr = 32'h3004;
    got = 1'b0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (b.bus_err) begin
        got = 1'b1;
        break;
      end
      if (b.bus_req) n++;
    end
    chk("tmo_err_seen",  32'(got),         32'd1);
    chk("tmo_busy_cyc",  32'(n),           32'd4);
    chk("tmo_mem_valid", 32'(b.mem_valid), 32'd1);
    chk("tmo_mem_rdata", b.mem_rdata,      32'd0);
    b.mem_req = 1'b0;
    @(negedge clk);
    #1;
    chk("tmo_err_pulse", 32'(b.bus_err),   32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
